// File: rtl/stopwatch_counter.sv
// stopwatch_counter: centisecond stopwatch/timer feeding the MM:SS.cc display path.
// Divides the board clock down to a 100 Hz tick and counts up or down, saturating at 0 and MAX_CS.
// Optional feature: define STOPWATCH_LAP_HOLD_EN to add a lap-hold register that freezes the
// displayed value while the live count keeps running.
module stopwatch_counter #(
    parameter int TICKS_PER_CS = 500000,
    parameter int MAX_CS       = 599999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [19:0] load_value,
    input  logic        count_down,
    input  logic        lap,
    output logic [19:0] value,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_CS - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [19:0]   MAX_VAL    = 20'(MAX_CS);
    localparam logic [19:0]   ONE_CS     = 20'd1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_n;
    logic [19:0]   count, count_n;
    logic [PW-1:0] presc, presc_n;
    logic          ss_prev, clr_prev, ld_prev;
    logic          ss_ev, clr_ev, ld_ev, tick;
    logic [19:0]   load_clamped;

    // Remember last button levels so a held button yields a single event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_prev  <= 1'b0;
            clr_prev <= 1'b0;
            ld_prev  <= 1'b0;
        end else begin
            ss_prev  <= start_stop;
            clr_prev <= clear;
            ld_prev  <= load;
        end
    end

    assign ss_ev        = start_stop & ~ss_prev;
    assign clr_ev       = clear & ~clr_prev;
    assign ld_ev        = load & ~ld_prev;
    assign tick         = (state == RUN) && (presc == PRESC_LAST);
    assign load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    // Next state, count and prescaler; clear beats load beats start_stop, and a button event
    // takes precedence over a tick landing in the same cycle.
    always_comb begin
        state_n = state;
        count_n = count;
        presc_n = presc;
        if (clr_ev) begin
            state_n = IDLE;
            count_n = '0;
            presc_n = '0;
        end else if (ld_ev) begin
            state_n = PAUSE;
            count_n = load_clamped;
            presc_n = '0;
        end else if (ss_ev && (state != DONE)) begin
            if (state == RUN) begin
                state_n = PAUSE;
            end else begin
                state_n = RUN;
                presc_n = '0;
            end
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                if (count_down) begin
                    if (count == '0) begin
                        state_n = DONE;
                    end else begin
                        count_n = count - ONE_CS;
                        if (count == ONE_CS) begin
                            state_n = DONE;
                        end
                    end
                end else begin
                    if (count >= MAX_VAL) begin
                        count_n = MAX_VAL;
                        state_n = DONE;
                    end else begin
                        count_n = count + ONE_CS;
                        if (count_n == MAX_VAL) begin
                            state_n = DONE;
                        end
                    end
                end
            end else begin
                presc_n = presc + PRESC_ONE;
            end
        end
    end

    // Live state registers; running/done are registered alongside the state they report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            presc   <= presc_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_prev, lap_ev, hold_active;
    logic [19:0] hold;

    assign lap_ev = lap & ~lap_prev;

    // Lap hold: first lap edge freezes the display, second one releases it; clear/load release too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_prev    <= 1'b0;
            hold_active <= 1'b0;
            hold        <= '0;
        end else begin
            lap_prev <= lap;
            if (clr_ev || ld_ev) begin
                hold_active <= 1'b0;
            end else if (lap_ev) begin
                if (hold_active) begin
                    hold_active <= 1'b0;
                end else if ((state == RUN) || (state == PAUSE)) begin
                    hold_active <= 1'b1;
                    hold        <= count;
                end
            end
        end
    end

    assign value = hold_active ? hold : count;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign value      = count;
`endif

endmodule
